alu_share_arbiter: RTL
======================

# alu_share_arbiter

Arbitrates two independent requesters onto one shared 32-bit ALU datapath (AND, OR, ADD, SUB) and returns each result through a single-entry output register with a valid/ready handshake. It sits between the issue logic (two requester ports) and the result consumer. Throughput is one operation per cycle when the consumer never stalls.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width.

Ports (clock and reset first):
- `clock`  in  1  single clock for the block; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_op`  in  2  requester 0 opcode: 00 AND, 01 OR, 10 ADD, 11 SUB.
- `req0_a`, `req0_b`  in  WIDTH  requester 0 operands.
- `req0_ready`  out  1  requester 0 is accepted this cycle.
- `req1_valid`, `req1_op`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `res_valid`  out  1  result register holds a result.
- `res_ready`  in  1  consumer takes the result this cycle.
- `res_data`  out  WIDTH  result.
- `res_id`  out  1  requester that produced `res_data`.
- `res_ovf`  out  1  signed overflow for ADD/SUB; 0 for AND/OR.

## Operation
- Output-register FSM with two states:
  - EMPTY: `res_valid`=0.
  - FULL: `res_valid`=1.
- `can_accept` = (state==EMPTY) | `res_ready`.
- Grant selection:
  - At most one `reqN_ready` is high per cycle.
  - `reqN_ready` = `can_accept` & `reqN_valid` & (requester N is granted).
  - `reqN_ready` is combinational from `reqN_valid` and state. It never depends on `reqN_op`, `reqN_a` or `reqN_b`.
- An accept occurs when `reqN_valid` & `reqN_ready` are both high. On accept, the ALU result, `res_id` and `res_ovf` load into the output register, and the state becomes FULL.
- State transitions:
  - EMPTY to FULL on accept.
  - FULL to FULL on drain and accept in the same cycle (back-to-back).
  - FULL to EMPTY on drain with no accept.
  - FULL holds, with all outputs frozen, while `res_ready`=0.
- Arithmetic:
  - ADD is A+B modulo 2^WIDTH.
  - SUB is A+~B+1 modulo 2^WIDTH.
  - `res_ovf` = operand sign bits agree (B inverted for SUB) and result sign differs.
  - AND and OR are bitwise; `res_ovf`=0.
- Priority pointer `last_id`: a 1-bit register updated on every accept to the granted id. It is consulted only when both requesters are valid.
- A lone valid requester is granted regardless of `last_id`.

## Timing
- Reset values: `res_valid`=0, `res_data`=0, `res_id`=0, `res_ovf`=0, state EMPTY, `last_id`=1 (requester 0 wins the first conflict).
- `req0_ready` and `req1_ready` are 0 while `reset`=1.
- Latency: an accept at edge N makes `res_valid`=1 with the result after edge N.
- Outputs are registered; no combinational path from `reqN_*` to `res_*`.
- Reset asserted while FULL discards the held result: `res_valid`=0 after that edge, and `last_id` returns to 1.
- A requester must hold `reqN_*` stable until ready. The block tolerates a withdrawn `valid` without error.

## Configuration
- `ALU_SHARE_RR_EN` defined: round-robin. On conflict, grant the requester not equal to `last_id`.
- Not defined: fixed priority. On conflict, requester 0 always wins and `last_id` is unused (synthesised away). Requester 1 can starve.

## Structure
- Shared package `alu_pkg`:
  - opcode constants `ALU_OP_AND`=2'b00, `ALU_OP_OR`=2'b01, `ALU_OP_ADD`=2'b10, `ALU_OP_SUB`=2'b11.
  - state encodings `ST_EMPTY`, `ST_FULL`.
- One sub-module, `alu_core`: purely combinational. Inputs op, a, b; outputs result, ovf. It reuses the existing bitwise and adder circuits.
- Arbiter, FSM and output register live in the top.

## Test plan
- Reset: assert `reset` 2 cycles with both requesters valid. Response: `req0_ready`=`req1_ready`=0, `res_valid`=0, `res_data`=0.
- Single OR: req0 OR 0xF0F0_0000, 0x0000_0F0F; `res_ready`=1. Response: next cycle `res_data`=0xF0F0_0F0F, `res_id`=0, `res_ovf`=0.
- Conflict: both valid for 4 cycles with `res_ready`=1. With `ALU_SHARE_RR_EN`, `res_id` sequence is 0,1,0,1. Without it, the sequence is 0,0,0,0.
- Backpressure: FULL with `res_ready`=0 for 3 cycles. Response: both readys 0 and outputs unchanged. On raising `res_ready`, a pending request is accepted in that same cycle.
- Arithmetic:
  - ADD 0x7FFF_FFFF+0x1 gives 0x8000_0000, ovf=1.
  - SUB 0x0-0x1 gives 0xFFFF_FFFF, ovf=0.
  - SUB 0x8000_0000-0x1 gives 0x7FFF_FFFF, ovf=1.
- Mid-operation reset: pulse `reset` while FULL with `res_ready`=0. Response: `res_valid`=0 next cycle. The next conflict grants requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing arbiter: opcode values and output-register states.
package alu_pkg;

    localparam logic [1:0] ALU_OP_AND = 2'b00;
    localparam logic [1:0] ALU_OP_OR  = 2'b01;
    localparam logic [1:0] ALU_OP_ADD = 2'b10;
    localparam logic [1:0] ALU_OP_SUB = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational shared ALU: bitwise AND/OR plus one adder that serves both ADD and SUB.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;

    // SUB folds into the adder as a + ~b + 1
    assign is_sub = (op == ALU_OP_SUB);
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            ALU_OP_AND: result = a & b;
            ALU_OP_OR:  result = a | b;
            default: begin
                result = sum;
                ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two requesters share one ALU; results leave through a single-entry valid/ready register.
// Define ALU_SHARE_RR_EN for round-robin on conflict; otherwise requester 0 has fixed priority.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_ovf
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] res_data_reg;
    logic             res_id_reg;
    logic             res_ovf_reg;

    logic [1:0]       req_valid;
    logic [1:0]       grant;
    logic [1:0]       req_ready_vec;
    logic             can_accept;
    logic             accept;
    logic             sel_id;
    logic             prefer1;

    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic             alu_ovf;

    assign req_valid  = {req1_valid, req0_valid};
    assign can_accept = (state_reg == ST_EMPTY) || res_ready;

`ifdef ALU_SHARE_RR_EN
    logic last_id_reg;

    // Give the conflict to whichever requester did not win the last accept
    assign prefer1 = ~last_id_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_id_reg <= 1'b1;
        end else if (accept) begin
            last_id_reg <= sel_id;
        end
    end
`else
    assign prefer1 = 1'b0;
`endif

    assign grant[0] = req_valid[0] & (~req_valid[1] | ~prefer1);
    assign grant[1] = req_valid[1] & (~req_valid[0] |  prefer1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready_vec[gi] = can_accept & grant[gi] & ~reset;
        end
    endgenerate

    assign req0_ready = req_ready_vec[0];
    assign req1_ready = req_ready_vec[1];
    assign accept     = |req_ready_vec;
    assign sel_id     = req_ready_vec[1];

    assign alu_op = sel_id ? req1_op : req0_op;
    assign alu_a  = sel_id ? req1_a  : req0_a;
    assign alu_b  = sel_id ? req1_b  : req0_b;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (res_ready && !accept) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_EMPTY;
            res_data_reg <= '0;
            res_id_reg   <= 1'b0;
            res_ovf_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                res_data_reg <= alu_result;
                res_id_reg   <= sel_id;
                res_ovf_reg  <= alu_ovf;
            end
        end
    end

    assign res_valid = (state_reg == ST_FULL);
    assign res_data  = res_data_reg;
    assign res_id    = res_id_reg;
    assign res_ovf   = res_ovf_reg;

endmodule
